// File: rtl/muxn_scan_if.sv
// rtl/muxn_scan_if.sv - channel words, select/scan controls and tagged output of muxn_scan
interface muxn_scan_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SELW-1:0]           sel;
  logic                      load;
  logic                      mode;
  logic [CHANNELS-1:0]       mask;
  logic [WIDTH-1:0]          m;
  logic [SELW-1:0]           ch;
  logic                      valid;
  logic                      step;
  logic                      err;

  modport master (
    output data_in, sel, load, mode, mask,
    input  m, ch, valid, step, err
  );

  modport slave (
    input  data_in, sel, load, mode, mask,
    output m, ch, valid, step, err
  );
endinterface

// File: rtl/muxn_scan.sv
// rtl/muxn_scan.sv - registered N-channel mux with manual select and masked round-robin scan
module muxn_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int DWELL    = 8
) (
  input  logic       clk,
  input  logic       reset,
  muxn_scan_if.slave bus
);
  localparam int              CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int              SW1    = SELW + 1;
  localparam logic [CW-1:0]   LAST   = CW'(DWELL - 1);
  localparam logic [SELW:0]   CH_LIM = SW1'(CHANNELS);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] cur_ch, cur_d, nxt_ch;
  logic [CW-1:0]   cnt, cnt_d;
  logic            step_d, err_d, sel_bad, found;
  logic [SELW:0]   cand;
  logic [WIDTH-1:0] words [CHANNELS];

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      words[k] = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  // First enabled channel after cur_ch, wrapping; lands back on cur_ch if it is the only one.
  always_comb begin
    nxt_ch = cur_ch;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = {1'b0, cur_ch} + SW1'(i);
      if (cand >= CH_LIM) cand = cand - CH_LIM;
      if (!found && bus.mask[cand[SELW-1:0]]) begin
        nxt_ch = cand[SELW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = bus.mode ? SCAN : MANUAL;
    cur_d   = cur_ch;
    cnt_d   = cnt;
    step_d  = 1'b0;
    err_d   = 1'b0;
    sel_bad = {1'b0, bus.sel} >= CH_LIM;
    if (!bus.mode) begin
      cnt_d = '0;
      if (bus.load) begin
        if (sel_bad) err_d = 1'b1;
        else         cur_d = bus.sel;
      end
    end else if (bus.load && !sel_bad) begin
      cur_d = bus.sel;
      cnt_d = '0;
    end else begin
      if (bus.load) err_d = 1'b1;
      // Entering scan restarts the dwell so the first advance is a full period away.
      if (state_q == MANUAL || bus.mask == '0) begin
        cnt_d = '0;
      end else if (cnt == LAST) begin
        cnt_d  = '0;
        cur_d  = nxt_ch;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MANUAL;
      cur_ch    <= '0;
      cnt       <= '0;
      bus.m     <= '0;
      bus.ch    <= '0;
      bus.valid <= 1'b0;
      bus.step  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ch    <= cur_d;
      cnt       <= cnt_d;
      bus.m     <= words[cur_ch];
      bus.ch    <= cur_ch;
      bus.valid <= !bus.mode || (bus.mask != '0);
      bus.step  <= step_d;
      bus.err   <= err_d;
    end
  end
endmodule

// File: doc/muxn_scan.md
# muxn_scan

Parametrised, registered N-channel, W-bit multiplexer, successor to the gate-level 2-to-1 mux. It selects one of CHANNELS input words either manually, from a latched select, or automatically, by round-robin scanning of masked channels with a programmable dwell time. It drives a registered output word tagged with its source channel. It sits between the switch/sensor input banks and the display/readout logic.

## Interface
- WIDTH, 4, bits per channel word (≥1)
- CHANNELS, 4, number of input channels (2..16)
- SELW, 2, select width; must equal ceil(log2(CHANNELS))
- DWELL, 8, cycles spent on each channel in scan mode (≥1)

- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- data_in  input  CHANNELS*WIDTH  packed channel words; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SELW  requested channel
- load  input  1  capture sel into the current-channel register
- mode  input  1  0 = manual, 1 = scan
- mask  input  CHANNELS  scan enable per channel; bit k = 1 includes channel k in the scan
- m  output  WIDTH  registered selected word
- ch  output  SELW  channel that produced m
- valid  output  1  m/ch are meaningful
- step  output  1  one-cycle pulse: a dwell period expired and the scanner advanced
- err  output  1  one-cycle pulse: load with sel ≥ CHANNELS

## Operation
- Internal registers:
  - cur_ch (SELW bits)
  - dwell counter cnt (0..DWELL-1)
  - registered mode_q, used for edge detection
- Reset values: cur_ch=0, cnt=0, mode_q=0, m=0, ch=0, valid=0, step=0, err=0.
- Output path, every cycle: m <= data_in[cur_ch]; ch <= cur_ch; valid <= (mode==0) | (mask!=0).
- MANUAL state (mode=0):
  - load with sel < CHANNELS: cur_ch <= sel.
  - load with sel ≥ CHANNELS: cur_ch unchanged; err pulses.
  - cnt held at 0; mask ignored; step=0.
- SCAN state (mode=1):
  - With mask != 0, cnt increments each cycle.
  - When cnt==DWELL-1: cnt <= 0, step pulses, and cur_ch <= the first channel with its mask bit set, searching cur_ch+1, cur_ch+2, … and wrapping modulo CHANNELS.
  - If cur_ch is the only enabled channel, cur_ch stays and step still pulses.
  - A disabled cur_ch is left at the next expiry. It is not left immediately.
  - mask==0: cnt held at 0, cur_ch held, step=0, valid goes 0 on the next cycle.
- Load in SCAN:
  - Valid sel: cur_ch <= sel and cnt <= 0. The jump is allowed even if mask[sel]=0.
  - Invalid sel: err pulses; scanning continues unaffected.
- Mode transitions:
  - 0→1, detected via mode_q: cnt <= 0; scan proceeds from the current cur_ch, and the first advance occurs DWELL cycles later.
  - 1→0: cnt <= 0; cur_ch frozen at its present value.
- Priority, highest first: reset > load > dwell expiry > count.

## Timing
- Data latency: m and ch at edge t+1 reflect data_in and cur_ch sampled at edge t. A change of cur_ch at edge t appears on m/ch at edge t+1.
- Manual load latency: load at edge t, then m shows data_in[sel] after edge t+1 (2-cycle load-to-output).
- Scan period: with all channels enabled and no loads, cur_ch changes every DWELL cycles. step is asserted in the cycle following the edge at which cur_ch changes, i.e. coincident with the new cur_ch and one cycle before m shows the new channel.
- DWELL=1: advance and step pulse every cycle.
- Wrap-around: channel CHANNELS-1 → 0, or to the lowest enabled channel.
- Reset mid-scan: all state returns to reset values at the edge where reset=1; no partial advance.
- Unused select codes (CHANNELS < 2^SELW) never appear on cur_ch or ch.

## Test plan
- Reset: hold reset 2 cycles mid-scan → m=0, ch=0, valid=0, step=0, err=0 on the next edge.
- Manual select, CHANNELS=4, WIDTH=4: data_in={D,C,B,A}; load sel=2 at edge t → ch=2, m=4'hC after edge t+1, valid=1.
- Invalid select, CHANNELS=3, SELW=2: load sel=3 → err pulses 1 cycle, ch unchanged.
- Scan with DWELL=3, mask=4'b1111 → ch sequence 0,1,2,3,0, each held 3 cycles; step pulses once per change.
- Masked scan, mask=4'b1010, starting at ch=0 → advances to 1, then 3, 1, 3, …
- Masked scan, mask=0 → ch frozen, valid=0, step never pulses.
- Collision: load sel=0 in the same cycle as a dwell expiry at ch=2 → ch=0 and cnt restarts; no advance to 3.
